core_pc_ras: RTL and testbench
==============================

CORE_PC_RAS -- requirements
Module: core_pc_ras

Interface
REQ-001 SHALL have parameter BOOT_ADDR, logic [31:0], default 32'h0: boot word address; the low WORD_ADDR_WIDTH bits are used.
REQ-002 SHALL have parameter WORD_ADDR_WIDTH, int, default 30: PC width in words.
REQ-003 SHALL have parameter TRAP_ADDR, logic [31:0], default 32'h1: trap vector word address; the low WORD_ADDR_WIDTH bits are used.
REQ-004 SHALL have parameter RAS_DEPTH, int, default 4: return-address-stack entries; power of two, at least 2.
REQ-005 SHALL have port clk_i  in  1  clock, rising edge.
REQ-006 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port stall_i  in  1  freeze PC and RAS.
REQ-008 SHALL have port incr_i  in  1  advance to sequential PC.
REQ-009 SHALL have port redirect_i  in  1  load redirect_waddr_i.
REQ-010 SHALL have port redirect_waddr_i  in  WORD_ADDR_WIDTH  jump/branch target.
REQ-011 SHALL have port call_i  in  1  push the return address (valid with redirect_i).
REQ-012 SHALL have port ret_i  in  1  pop the RAS and load the predicted return.
REQ-013 SHALL have port trap_i  in  1  load TRAP_ADDR.
REQ-014 SHALL have port pc_waddr_o  out  WORD_ADDR_WIDTH  current PC.
REQ-015 SHALL have port next_pc_waddr_o  out  WORD_ADDR_WIDTH  pc_waddr_o+1, combinational.
REQ-016 SHALL have port ras_top_o  out  WORD_ADDR_WIDTH  top-of-stack entry; 0 when empty.
REQ-017 SHALL have port ras_empty_o  out  1  stack count is 0.
REQ-018 SHALL have port ras_ovf_o  out  1  one-cycle pulse on a push when full.
REQ-019 SHALL have port ras_unf_o  out  1  one-cycle pulse on a pop when empty.

Function
REQ-020 SHALL select the next PC by priority: trap_i > redirect_i > ret_i > incr_i > hold.
REQ-021 SHALL apply trap_i even when stall_i=1; with stall_i=1 and trap_i=0, PC and RAS SHALL hold.
REQ-022 SHALL wrap PC+1 modulo 2^WORD_ADDR_WIDTH.
REQ-023 SHALL, on call_i&redirect_i (no trap), push pc_q+1 and load redirect_waddr_i; call_i without redirect_i SHALL be ignored.
REQ-024 SHALL, on ret_i (no trap or redirect), load the popped top when non-empty, or load pc_q+1 and pulse ras_unf_o when empty.
REQ-025 SHALL implement the RAS as a circular buffer: a push when full overwrites the oldest entry, count saturates at RAS_DEPTH, and ras_ovf_o pulses.
REQ-026 SHALL treat simultaneous call_i&redirect_i&ret_i as replace-top: count unchanged, top = pc_q+1, PC = redirect_waddr_i.
REQ-027 SHALL, on trap_i, flush the RAS (count=0) in the same edge.
REQ-028 SHALL give a latency of one clock from a control input to pc_waddr_o and RAS state.
REQ-029 SHALL keep ras_ovf_o and ras_unf_o low while stalled without trap.

Reset
REQ-030 SHALL, while rst_ni=0, hold pc_waddr_o=BOOT_ADDR[WORD_ADDR_WIDTH-1:0], RAS count=0, ras_empty_o=1, ras_top_o=0, ras_ovf_o=0, ras_unf_o=0.
REQ-031 SHALL discard in-flight operations on reset mid-operation; the first post-reset edge SHALL act on current inputs only.

Configuration
REQ-032 SHALL, with CORE_PC_RAS_EN defined, implement the RAS as specified.
REQ-033 SHALL, without CORE_PC_RAS_EN, omit the RAS storage; the block then:
- ignores call_i;
- treats ret_i as incr_i;
- ties ras_empty_o=1, ras_top_o=0, ras_ovf_o=0, ras_unf_o=0.

Structure
REQ-034 SHALL place pc_sel_e (HOLD, INCR, RET, REDIRECT, TRAP) in the shared package core_pkg.
REQ-035 SHALL place the RAS in sub-module core_ras (push, pop, flush, top, empty, ovf, unf), instantiated only under CORE_PC_RAS_EN.

Verification
REQ-036 SHALL cover: reset with BOOT_ADDR=0x40 -> pc=0x40, ras_empty_o=1; then 3 incr_i -> pc=0x43.
REQ-037 SHALL cover: at pc=0x10, call_i+redirect_i to 0x80 -> pc=0x80, ras_top_o=0x11; then ret_i -> pc=0x11, ras_empty_o=1.
REQ-038 SHALL cover: RAS_DEPTH=4 with 5 calls at pcs 1..5 -> ras_ovf_o pulses on the 5th; 4 returns yield 6,5,4,3; the 5th return pulses ras_unf_o.
REQ-039 SHALL cover: stall_i=1 with incr_i=1 and ret_i=1 -> pc and RAS unchanged; stall_i=1 with trap_i=1 -> pc=TRAP_ADDR, RAS flushed.
REQ-040 SHALL cover: WORD_ADDR_WIDTH=8 at pc=0xFF with incr_i -> pc=0x00, next_pc_waddr_o=0x01.
REQ-041 SHALL cover: with CORE_PC_RAS_EN undefined, ret_i at pc=0x20 -> pc=0x21 and all RAS outputs at tie-off values.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types: next-PC source selection.
package core_pkg;

    typedef enum logic [2:0] {
        HOLD,
        INCR,
        RET,
        REDIRECT,
        TRAP
    } pc_sel_e;

endpackage

// File: rtl/core_ras.sv
// Circular return-address stack: the oldest entry is overwritten on overflow,
// push+pop together replaces the top, and flush empties the stack.
module core_ras #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 30
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             empty_o,
    output logic             ovf_o,
    output logic             unf_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] tp_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic             unf_q;

    // tp_q indexes the current top; a push advances it, so a full push lands on the oldest slot
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            tp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            if (flush_i) begin
                cnt_q <= '0;
            end else if (push_i && pop_i) begin
                mem_q[tp_q] <= push_data_i;
            end else if (push_i) begin
                mem_q[tp_q + PTR_W'(1)] <= push_data_i;
                tp_q <= tp_q + PTR_W'(1);
                if (cnt_q == FULL) ovf_q <= 1'b1;
                else               cnt_q <= cnt_q + CNT_W'(1);
            end else if (pop_i) begin
                if (cnt_q == '0) begin
                    unf_q <= 1'b1;
                end else begin
                    tp_q  <= tp_q - PTR_W'(1);
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end
        end
    end

    assign empty_o = (cnt_q == '0);
    assign top_o   = empty_o ? '0 : mem_q[tp_q];
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;

endmodule

// File: rtl/core_pc_ras.sv
// Program counter with trap/redirect/return/increment selection and an optional
// return-address stack, enabled by defining CORE_PC_RAS_EN.
module core_pc_ras
    import core_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR       = 32'h0,
    parameter int          WORD_ADDR_WIDTH = 30,
    parameter logic [31:0] TRAP_ADDR       = 32'h1,
    parameter int          RAS_DEPTH       = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       stall_i,
    input  logic                       incr_i,
    input  logic                       redirect_i,
    input  logic [WORD_ADDR_WIDTH-1:0] redirect_waddr_i,
    input  logic                       call_i,
    input  logic                       ret_i,
    input  logic                       trap_i,
    output logic [WORD_ADDR_WIDTH-1:0] pc_waddr_o,
    output logic [WORD_ADDR_WIDTH-1:0] next_pc_waddr_o,
    output logic [WORD_ADDR_WIDTH-1:0] ras_top_o,
    output logic                       ras_empty_o,
    output logic                       ras_ovf_o,
    output logic                       ras_unf_o
);

    localparam int unsigned AW = WORD_ADDR_WIDTH;
    localparam logic [AW-1:0] BOOT_W = BOOT_ADDR[AW-1:0];
    localparam logic [AW-1:0] TRAP_W = TRAP_ADDR[AW-1:0];

    pc_sel_e       sel_c;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_d_c;
    logic [AW-1:0] pc_inc_c;
    logic [AW-1:0] top_c;
    logic          empty_c;
    logic          ret_en_c;
    logic          incr_en_c;

`ifdef CORE_PC_RAS_EN
    assign ret_en_c  = ret_i;
    assign incr_en_c = incr_i;
`else
    // Without a stack a return can only fall through to the next word
    assign ret_en_c  = 1'b0;
    assign incr_en_c = incr_i | ret_i;
`endif

    // Trap overrides the stall; everything else freezes under stall
    always_comb begin
        sel_c = HOLD;
        if (trap_i)          sel_c = TRAP;
        else if (stall_i)    sel_c = HOLD;
        else if (redirect_i) sel_c = REDIRECT;
        else if (ret_en_c)   sel_c = RET;
        else if (incr_en_c)  sel_c = INCR;
    end

    assign pc_inc_c = pc_q + AW'(1);

    always_comb begin
        pc_d_c = pc_q;
        case (sel_c)
            TRAP:     pc_d_c = TRAP_W;
            REDIRECT: pc_d_c = redirect_waddr_i;
            RET:      pc_d_c = empty_c ? pc_inc_c : top_c;
            INCR:     pc_d_c = pc_inc_c;
            default:  pc_d_c = pc_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pc_q <= BOOT_W;
        else         pc_q <= pc_d_c;
    end

    assign pc_waddr_o      = pc_q;
    assign next_pc_waddr_o = pc_inc_c;

`ifdef CORE_PC_RAS_EN
    logic push_c;
    logic pop_c;
    logic flush_c;

    // call+ret on a redirect replaces the top instead of pushing
    assign push_c  = (sel_c == REDIRECT) && call_i;
    assign pop_c   = (sel_c == RET) || (push_c && ret_i);
    assign flush_c = (sel_c == TRAP);

    core_ras #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (AW)
    ) u_ras (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push_c),
        .pop_i       (pop_c),
        .flush_i     (flush_c),
        .push_data_i (pc_inc_c),
        .top_o       (top_c),
        .empty_o     (empty_c),
        .ovf_o       (ras_ovf_o),
        .unf_o       (ras_unf_o)
    );
`else
    logic unused_call;
    assign unused_call = call_i;
    assign top_c       = '0;
    assign empty_c     = 1'b1;
    assign ras_ovf_o   = 1'b0;
    assign ras_unf_o   = 1'b0;
`endif

    assign ras_top_o   = top_c;
    assign ras_empty_o = empty_c;

endmodule

// File: tb/tb_core_pc_ras.sv
// Directed bench for core_pc_ras; expectations follow CORE_PC_RAS_EN.
module tb_core_pc_ras;

    localparam int unsigned AW  = 8;
    localparam int unsigned WAW = 30;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          stall_i, incr_i, redirect_i, call_i, ret_i, trap_i;
    logic [AW-1:0] redirect_waddr_i, pc_waddr_o, next_pc_waddr_o, ras_top_o;
    logic          ras_empty_o, ras_ovf_o, ras_unf_o;

    logic           w_redirect, w_incr, w_trap;
    logic [WAW-1:0] w_tgt, w_pc, w_next, w_top;
    logic           w_empty, w_ovf, w_unf;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    core_pc_ras #(
        .BOOT_ADDR       (32'h40),
        .WORD_ADDR_WIDTH (AW),
        .TRAP_ADDR       (32'h30),
        .RAS_DEPTH       (4)
    ) u_dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .stall_i          (stall_i),
        .incr_i           (incr_i),
        .redirect_i       (redirect_i),
        .redirect_waddr_i (redirect_waddr_i),
        .call_i           (call_i),
        .ret_i            (ret_i),
        .trap_i           (trap_i),
        .pc_waddr_o       (pc_waddr_o),
        .next_pc_waddr_o  (next_pc_waddr_o),
        .ras_top_o        (ras_top_o),
        .ras_empty_o      (ras_empty_o),
        .ras_ovf_o        (ras_ovf_o),
        .ras_unf_o        (ras_unf_o)
    );

    core_pc_ras u_wide (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .stall_i          (1'b0),
        .incr_i           (w_incr),
        .redirect_i       (w_redirect),
        .redirect_waddr_i (w_tgt),
        .call_i           (1'b0),
        .ret_i            (1'b0),
        .trap_i           (w_trap),
        .pc_waddr_o       (w_pc),
        .next_pc_waddr_o  (w_next),
        .ras_top_o        (w_top),
        .ras_empty_o      (w_empty),
        .ras_ovf_o        (w_ovf),
        .ras_unf_o        (w_unf)
    );

    typedef struct packed {
        logic          stall;
        logic          incr;
        logic          redirect;
        logic [AW-1:0] tgt;
        logic          call;
        logic          ret;
        logic          trap;
        logic [AW-1:0] pc;
        logic [AW-1:0] top;
        logic          empty;
        logic          ovf;
        logic          unf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic s, input logic inc, input logic rd, input logic [AW-1:0] t,
                                input logic c, input logic r, input logic tr, input logic [AW-1:0] pc,
                                input logic [AW-1:0] top, input logic e, input logic o, input logic u);
        vec_t v;
        v.stall = s; v.incr = inc; v.redirect = rd; v.tgt = t; v.call = c; v.ret = r; v.trap = tr;
        v.pc = pc; v.top = top; v.empty = e; v.ovf = o; v.unf = u;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk_i);
        stall_i = v.stall; incr_i = v.incr; redirect_i = v.redirect; redirect_waddr_i = v.tgt;
        call_i = v.call; ret_i = v.ret; trap_i = v.trap;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_vec(input int i, input vec_t v);
        logic [AW-1:0] nxt;
        nxt = v.pc + AW'(1);
        chk($sformatf("v%0d pc", i),    32'(pc_waddr_o),      32'(v.pc));
        chk($sformatf("v%0d next", i),  32'(next_pc_waddr_o), 32'(nxt));
        chk($sformatf("v%0d top", i),   32'(ras_top_o),       32'(v.top));
        chk($sformatf("v%0d empty", i), 32'(ras_empty_o),     32'(v.empty));
        chk($sformatf("v%0d ovf", i),   32'(ras_ovf_o),       32'(v.ovf));
        chk($sformatf("v%0d unf", i),   32'(ras_unf_o),       32'(v.unf));
    endtask

    initial begin
        rst_ni = 1'b0;
        stall_i = 1'b0; incr_i = 1'b0; redirect_i = 1'b0; redirect_waddr_i = '0;
        call_i = 1'b0; ret_i = 1'b0; trap_i = 1'b0;
        w_redirect = 1'b0; w_incr = 1'b0; w_trap = 1'b0; w_tgt = '0;

        repeat (2) @(posedge clk_i);
        #1;
        chk("reset pc",    32'(pc_waddr_o),  32'h40);
        chk("reset empty", 32'(ras_empty_o), 32'h1);
        chk("reset top",   32'(ras_top_o),   32'h0);
        chk("reset ovf",   32'(ras_ovf_o),   32'h0);
        chk("reset unf",   32'(ras_unf_o),   32'h0);
        chk("wide reset pc", 32'(w_pc),      32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        //             st inc rd tgt    ca rt tr  pc     top    e  o  u
`ifdef CORE_PC_RAS_EN
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, 8'h41, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, 8'h42, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, 8'h43, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h10, 0, 0, 0, 8'h10, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h80, 1, 0, 0, 8'h80, 8'h11, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 0, 8'h11, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h01, 0, 0, 0, 8'h01, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h02, 1, 0, 0, 8'h02, 8'h02, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h03, 1, 0, 0, 8'h03, 8'h03, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h04, 1, 0, 0, 8'h04, 8'h04, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h05, 1, 0, 0, 8'h05, 8'h05, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h06, 1, 0, 0, 8'h06, 8'h06, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 0, 8'h06, 8'h05, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 0, 8'h05, 8'h04, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 0, 8'h04, 8'h03, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 0, 8'h03, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 0, 8'h04, 8'h00, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, 8'h05, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h20, 1, 0, 0, 8'h20, 8'h06, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 8'h00, 0, 1, 0, 8'h20, 8'h06, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 1, 8'h30, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h50, 1, 0, 0, 8'h50, 8'h31, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h60, 1, 1, 0, 8'h60, 8'h51, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 0, 8'h51, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h77, 0, 0, 1, 8'h30, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h70, 0, 1, 0, 8'h70, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 0, 0, 8'h71, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h71, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'hFF, 0, 0, 0, 8'hFF, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0));
`else
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, 8'h41, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, 8'h42, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, 8'h43, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h20, 0, 0, 0, 8'h20, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 0, 8'h21, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h80, 1, 0, 0, 8'h80, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 0, 8'h81, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 1, 0, 8'h82, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h90, 1, 1, 0, 8'h90, 8'h00, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 8'h00, 0, 1, 0, 8'h90, 8'h00, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 1, 8'h30, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 8'h77, 0, 0, 1, 8'h30, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h30, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'hFF, 0, 0, 0, 8'hFF, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0));
`endif

        foreach (tbl[i]) begin
            apply(tbl[i]);
            chk_vec(i, tbl[i]);
        end

        // Reset asserted mid-call: the call must be discarded entirely
        @(negedge clk_i);
        stall_i = 1'b0; incr_i = 1'b0; redirect_i = 1'b1; redirect_waddr_i = 8'h90;
        call_i = 1'b1; ret_i = 1'b0; trap_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        chk("midrst pc async", 32'(pc_waddr_o),  32'h40);
        chk("midrst empty",    32'(ras_empty_o), 32'h1);
        @(posedge clk_i);
        #1;
        chk("midrst pc held",  32'(pc_waddr_o),  32'h40);
        chk("midrst top",      32'(ras_top_o),   32'h0);
        @(negedge clk_i);
        redirect_i = 1'b0; call_i = 1'b0; incr_i = 1'b1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        chk("postrst pc",      32'(pc_waddr_o),  32'h41);
        chk("postrst empty",   32'(ras_empty_o), 32'h1);
        @(negedge clk_i);
        incr_i = 1'b0;

        // Default-parameter instance: full 30-bit wrap and default trap vector
        w_redirect = 1'b1; w_tgt = 30'h3FFF_FFFF;
        @(posedge clk_i);
        #1;
        chk("wide pc max",   32'(w_pc),   32'h3FFF_FFFF);
        chk("wide next max", 32'(w_next), 32'h0);
        @(negedge clk_i);
        w_redirect = 1'b0; w_incr = 1'b1;
        @(posedge clk_i);
        #1;
        chk("wide pc wrap",   32'(w_pc),   32'h0);
        chk("wide next wrap", 32'(w_next), 32'h1);
        @(negedge clk_i);
        w_incr = 1'b0; w_trap = 1'b1;
        @(posedge clk_i);
        #1;
        chk("wide trap pc",  32'(w_pc),    32'h1);
        chk("wide empty",    32'(w_empty), 32'h1);
        chk("wide top",      32'(w_top),   32'h0);
        chk("wide ovf unf",  32'({w_ovf, w_unf}), 32'h0);
        @(negedge clk_i);
        w_trap = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
